proc_int_div_iterative: RTL
===========================

Name: proc_int_div_iterative

Overview:
- Multi-cycle iterative integer divide/remainder unit for the pipelined processor's X stage.
- Complements the single-cycle ALU; the pipeline steers DIV/DIVU/REM/REMU here.
- Restoring division, one quotient bit per cycle.
- Request and response each use a val/rdy handshake, so the stage can stall on either side.

Parameters:
nbits, 32, operand/result width; also the number of iterations per divide

Ports:
clk        input   1      clock, all state updates on rising edge
reset      input   1      asynchronous, active-high reset
req_val    input   1      request valid
req_rdy    output  1      unit can accept a request
req_fn     input   2      0=DIV, 1=DIVU, 2=REM, 3=REMU
req_a      input   nbits  dividend
req_b      input   nbits  divisor
resp_val   output  1      result valid
resp_rdy   input   1      consumer accepts result
resp_data  output  nbits  quotient (DIV/DIVU) or remainder (REM/REMU)

Behaviour:
- Reset, asserted at any time including mid-operation:
  - Go to IDLE; abort any in-flight divide; no response issued.
  - Outputs while in reset: req_rdy=1, resp_val=0, resp_data=0.
  - Counter, remainder, quotient and divisor registers clear to 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - req_rdy=1, resp_val=0.
  - A request is accepted on an edge where req_val&&req_rdy. That edge latches fn and the operand signs, and moves to CALC.
  - Signed fns (0,2): operands are loaded as magnitudes (two's-complement negate if the MSB is set).
  - Unsigned fns load operands as-is.
  - Remainder register loads 0; counter loads nbits.
- CALC:
  - req_rdy=0, resp_val=0.
  - Each edge: shift {rem,quo} left 1. If the shifted rem >= divisor, subtract the divisor and set quo[0]=1. Decrement the counter.
  - Width rule: the compare/subtract is done nbits+1 wide so no carry is lost.
  - When the counter reaches 0, the next edge moves to DONE.
- Latency:
  - Fixed; there is no early termination, including for zero divisors.
  - For a request accepted on edge E, iterations occur on edges E+1..E+nbits.
  - resp_val is first high in the cycle after edge E+nbits+1 (33 edges after E for nbits=32).
- DONE:
  - resp_val=1, req_rdy=0.
  - resp_data is registered and held stable while resp_val=1, including under backpressure.
  - On an edge with resp_val&&resp_rdy, go to IDLE; req_rdy rises in the following cycle.
  - No request is accepted in the same cycle as a response.
- Sign fixup, applied when entering DONE:
  - Quotient is negated if the operand signs differ (signed fns only).
  - Remainder takes the sign of the dividend (signed fns only).
- Corner cases (RISC-V M semantics, produced by the datapath rather than special-cased logic wherever possible):
  - Divide by zero: quotient = all ones (0xFFFFFFFF) for both DIV and DIVU; remainder = dividend.
  - Signed overflow, -2^(nbits-1) / -1: quotient = -2^(nbits-1); remainder = 0.
- Inputs req_a/req_b/req_fn are ignored outside the accepting edge; they may change freely during CALC/DONE.
- Unknown values on req_fn never occur (2-bit field is fully decoded).

Test Plan:
- Latency: DIVU a=100 b=7 accepted at edge E, resp_rdy=1 → resp_data=14 with resp_val first high after edge E+33. REMU with the same operands → 2.
- Signed: DIV a=-7 b=2 → 0xFFFFFFFD (-3); REM a=-7 b=2 → 0xFFFFFFFF (-1); DIV a=7 b=-2 → 0xFFFFFFFD; REM a=7 b=-2 → 1.
- Corners:
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV -5/0 → 0xFFFFFFFF; REM -5/0 → 0xFFFFFFFB.
- Backpressure: hold resp_rdy=0 for 10 cycles after resp_val rises → resp_data constant, resp_val=1, req_rdy=0 throughout. Then raise resp_rdy → IDLE one edge later.
- Reset mid-CALC: assert reset asynchronously 10 cycles into a divide → resp_val=0 and req_rdy=1 immediately; a new DIVU 9/3 issued after reset returns 3 with normal latency.
- Back-to-back: 20 random requests (mixed fn, random operands including 0 and extreme values), req_val held high and random resp_rdy stalls → each result matches the reference model; no request is lost or duplicated.

Source files
------------

// File: rtl/proc_int_div_iterative.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Operands are divided as magnitudes; signs are restored when the result is registered.
module proc_int_div_iterative #(
   parameter int nbits = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_val,
   output logic             req_rdy,
   input  logic [1:0]       req_fn,
   input  logic [nbits-1:0] req_a,
   input  logic [nbits-1:0] req_b,
   output logic             resp_val,
   input  logic             resp_rdy,
   output logic [nbits-1:0] resp_data
);

   localparam int cw = $clog2(nbits + 1);
   localparam logic [cw-1:0] cnt_init = cw'(nbits);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t state, state_nxt;

   logic [cw-1:0]    cnt;
   logic [nbits-1:0] rem, quo, dvs, res;
   logic [1:0]       fn;
   logic             a_sgn, b_sgn;

   logic             a_neg, b_neg, ge;
   logic             neg_q, neg_r;
   logic [nbits:0]   rem_sh, rem_sub;
   logic [nbits-1:0] q_fix, r_fix;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      req_rdy   = 1'b0;
      resp_val  = 1'b0;
      unique case (state)
         IDLE: begin
            req_rdy = 1'b1;
            if (req_val) state_nxt = CALC;
         end
         CALC: begin
            if (cnt == '0) state_nxt = DONE;
         end
         DONE: begin
            resp_val = 1'b1;
            if (resp_rdy) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // fn[0]==0 selects the signed variants
   assign a_neg = ~req_fn[0] & req_a[nbits-1];
   assign b_neg = ~req_fn[0] & req_b[nbits-1];

   // nbits+1 wide so the shifted-out remainder bit takes part in the compare
   assign rem_sh  = {rem, quo[nbits-1]};
   assign rem_sub = rem_sh - {1'b0, dvs};
   assign ge      = ~rem_sub[nbits];

   // a zero divisor yields all-ones regardless of the dividend sign
   assign neg_q = ~fn[0] & (a_sgn ^ b_sgn) & (|dvs);
   assign neg_r = ~fn[0] & a_sgn;
   assign q_fix = neg_q ? -quo : quo;
   assign r_fix = neg_r ? -rem : rem;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt   <= '0;
         rem   <= '0;
         quo   <= '0;
         dvs   <= '0;
         res   <= '0;
         fn    <= '0;
         a_sgn <= 1'b0;
         b_sgn <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_val) begin
                  fn    <= req_fn;
                  a_sgn <= a_neg;
                  b_sgn <= b_neg;
                  quo   <= a_neg ? -req_a : req_a;
                  dvs   <= b_neg ? -req_b : req_b;
                  rem   <= '0;
                  cnt   <= cnt_init;
               end
            end
            CALC: begin
               if (cnt != '0) begin
                  rem <= ge ? rem_sub[nbits-1:0] : rem_sh[nbits-1:0];
                  quo <= {quo[nbits-2:0], ge};
                  cnt <= cnt - cw'(1);
               end else begin
                  res <= fn[1] ? r_fix : q_fix;
               end
            end
            DONE: begin
            end
            default: begin
            end
         endcase
      end
   end

   assign resp_data = res;

endmodule
